// File: rtl/module_cpu_core_p_if.sv
// RAM request/acknowledge bus between the CPU core (master) and its memory (slave).
interface module_cpu_core_p_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/module_cpu_core_p.sv
// Parametrised 8080-subset CPU core on a req/ack RAM bus.
// Optional CALL/RET stack support is enabled by defining CPU_STACK_EN.
module module_cpu_core_p #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic                clk_qzt,
  input  logic                reset_n,
  input  logic                en,
  module_cpu_core_p_if.master bus,
  output logic                halted,
  output logic [3:0]          flags,
  output logic [ADDR_W-1:0]   dbg_pc
);
  localparam logic [7:0] OP_MVI_B = 8'h06, OP_MVI_A = 8'h3E, OP_HLT   = 8'h76;
  localparam logic [7:0] OP_MOV_BA = 8'h47, OP_MOV_AB = 8'h78, OP_MOV_BC = 8'h41, OP_MOV_CB = 8'h48;
  localparam logic [7:0] OP_MOV_BH = 8'h44, OP_MOV_HB = 8'h60, OP_MOV_BL = 8'h45, OP_MOV_LB = 8'h68;
  localparam logic [7:0] OP_MOV_MB = 8'h70, OP_MOV_BM = 8'h46, OP_ADD_B = 8'h80, OP_ADD_M = 8'h86;
  localparam logic [7:0] OP_SUB_B = 8'h90, OP_CMP_B = 8'hB8, OP_JMP = 8'hC3;
  localparam logic [7:0] OP_JZ = 8'hCA, OP_JNZ = 8'hC2, OP_JC = 8'hDA;

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_OPND, S_MEM, S_HALT} state_t;

  state_t            st, nxt;
  logic [ADDR_W-1:0] pc, sp;
  logic [DATA_W-1:0] a, b, c, h, l, ir, tmp;
  logic [3:0]        flg;   // {S,Z,P,CY}
  logic [7:0]        op;
  logic              is_mvi, is_jcc, jcc_take, is_mem, is_call, is_ret;
  logic [DATA_W:0]   add_r, addm_r, sub_r;

  function automatic logic [3:0] alu_flags(input logic [DATA_W:0] r);
    return {r[DATA_W-1], ~|r[DATA_W-1:0], ~^r[DATA_W-1:0], r[DATA_W]};
  endfunction

  assign op       = ir[7:0];
  assign is_mvi   = (op == OP_MVI_A) || (op == OP_MVI_B);
  assign is_jcc   = (op == OP_JZ) || (op == OP_JNZ) || (op == OP_JC);
  assign jcc_take = ((op == OP_JZ) && flg[2]) || ((op == OP_JNZ) && !flg[2]) || ((op == OP_JC) && flg[0]);
  assign is_mem   = (op == OP_MOV_MB) || (op == OP_MOV_BM) || (op == OP_ADD_M);
`ifdef CPU_STACK_EN
  assign is_call  = (op == 8'hCD);
  assign is_ret   = (op == 8'hC9);
`else
  assign is_call  = 1'b0;
  assign is_ret   = 1'b0;
`endif

  assign add_r  = {1'b0, a} + {1'b0, b};
  assign addm_r = {1'b0, a} + {1'b0, bus.mem_rdata};
  assign sub_r  = {1'b0, a} - {1'b0, b};

  assign halted = (st == S_HALT) || ((st == S_EXEC) && (op == OP_HLT));
  assign flags  = flg;
  assign dbg_pc = pc;

  always_ff @(posedge clk_qzt or negedge reset_n) begin
    if (!reset_n)  st <= S_FETCH;
    else if (en)   st <= nxt;
  end

  // Bus outputs are decoded from state so a reset drops mem_req without waiting for a clock.
  always_comb begin
    nxt           = st;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = pc;
    bus.mem_wdata = '0;
    case (st)
      S_FETCH: begin
        bus.mem_req = reset_n;
        if (bus.mem_ack) nxt = S_EXEC;
      end
      S_EXEC: begin
        if (op == OP_HLT)                                      nxt = S_HALT;
        else if (is_mvi || op == OP_JMP || (is_jcc && jcc_take) || is_call) nxt = S_OPND;
        else if (is_mem || is_ret)                             nxt = S_MEM;
        else                                                   nxt = S_FETCH;
      end
      S_OPND: begin
        bus.mem_req  = reset_n;
        bus.mem_addr = pc + ADDR_W'(1);
        if (bus.mem_ack) nxt = is_call ? S_MEM : S_FETCH;
      end
      S_MEM: begin
        bus.mem_req   = reset_n;
        bus.mem_addr  = (is_call || is_ret) ? sp : h[ADDR_W-1:0];
        bus.mem_we    = (op == OP_MOV_MB) || is_call;
        bus.mem_wdata = is_call ? DATA_W'(pc + ADDR_W'(2)) : b;
        if (bus.mem_ack) nxt = S_FETCH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_qzt or negedge reset_n) begin
    if (!reset_n) begin
      pc  <= RESET_VEC;
      sp  <= '1;
      a   <= '0;
      b   <= '0;
      c   <= '0;
      h   <= '0;
      l   <= '0;
      ir  <= '0;
      tmp <= '0;
      flg <= '0;
    end else if (en) begin
      case (st)
        S_FETCH: if (bus.mem_ack) ir <= bus.mem_rdata;
        S_EXEC: begin
          if (is_jcc && !jcc_take)  pc <= pc + ADDR_W'(2);
          else if (nxt == S_FETCH)  pc <= pc + ADDR_W'(1);
          if (is_ret) sp <= sp + ADDR_W'(1);
          case (op)
            OP_MOV_BA: b <= a;
            OP_MOV_AB: a <= b;
            OP_MOV_BC: b <= c;
            OP_MOV_CB: c <= b;
            OP_MOV_BH: b <= h;
            OP_MOV_HB: h <= b;
            OP_MOV_BL: b <= l;
            OP_MOV_LB: l <= b;
            OP_ADD_B: begin a <= add_r[DATA_W-1:0]; flg <= alu_flags(add_r); end
            OP_SUB_B: begin a <= sub_r[DATA_W-1:0]; flg <= alu_flags(sub_r); end
            OP_CMP_B: flg <= alu_flags(sub_r);
            default: ;
          endcase
        end
        S_OPND: if (bus.mem_ack) begin
          if (op == OP_MVI_A)      begin a <= bus.mem_rdata; pc <= pc + ADDR_W'(2); end
          else if (op == OP_MVI_B) begin b <= bus.mem_rdata; pc <= pc + ADDR_W'(2); end
          else if (is_call)        tmp <= bus.mem_rdata;
          else                     pc <= bus.mem_rdata[ADDR_W-1:0];
        end
        S_MEM: if (bus.mem_ack) begin
          if (is_call) begin
            sp <= sp - ADDR_W'(1);
            pc <= tmp[ADDR_W-1:0];
          end else if (is_ret) begin
            pc <= bus.mem_rdata[ADDR_W-1:0];
          end else begin
            pc <= pc + ADDR_W'(1);
            if (op == OP_MOV_BM) b <= bus.mem_rdata;
            if (op == OP_ADD_M) begin a <= addm_r[DATA_W-1:0]; flg <= alu_flags(addm_r); end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
